coin_escrow_casher: RTL and testbench

Parametrised successor to the coin casher FSM for the arcade cabinet. It validates multi-denomination coins and accumulates credit against a configurable game price. Coins are held in an escrow FIFO so a player return request or an internal inactivity timeout refunds the exact coins inserted. It sits between the coin mech (insert pulses, coin codes) and the game controller (start/finish handshake).

---
 rtl/coin_escrow_casher_pkg.sv | 30 +++
 rtl/coin_escrow_casher_if.sv | 34 +++
 rtl/coin_escrow_casher_fifo.sv | 74 +++++++
 rtl/coin_escrow_casher.sv | 167 ++++++++++++++++
 tb/tb_coin_escrow_casher.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/coin_escrow_casher_pkg.sv
// Shared types and coin definitions for the escrow coin casher.
package coin_casher_pkg;

    localparam int COIN_CODE_W = 3;

    // Coin mech codes; every other code is invalid.
    localparam logic [COIN_CODE_W-1:0] COIN_1  = 3'd1;
    localparam logic [COIN_CODE_W-1:0] COIN_2  = 3'd2;
    localparam logic [COIN_CODE_W-1:0] COIN_5  = 3'd3;
    localparam logic [COIN_CODE_W-1:0] COIN_10 = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PLAY    = 2'd2,
        ST_REFUND  = 2'd3
    } state_e;

    // Credit units of a coin code; 0 marks an invalid code.
    function automatic logic [3:0] coin_value(input logic [COIN_CODE_W-1:0] code);
        case (code)
            COIN_1:  return 4'd1;
            COIN_2:  return 4'd2;
            COIN_5:  return 4'd5;
            COIN_10: return 4'd10;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_escrow_casher_if.sv
// Coin mech / game controller bus of the escrow coin casher.
interface coin_escrow_casher_if #(
    parameter int CREDIT_W = 8
);
    import coin_casher_pkg::*;

    logic                   coin_insert;
    logic [COIN_CODE_W-1:0] inserted_coin;
    logic                   return_coin;
    logic                   game_finish;
    logic                   coin_reject;
    logic                   spit_coin;
    logic [COIN_CODE_W-1:0] spit_code;
    logic                   eat_coins;
    logic                   game_active;
    logic                   timer_en;
    logic                   wait_ready;
    logic [CREDIT_W-1:0]    credit;

    // Cabinet side: coin mech and game controller.
    modport master (
        output coin_insert, inserted_coin, return_coin, game_finish,
        input  coin_reject, spit_coin, spit_code, eat_coins, game_active,
               timer_en, wait_ready, credit
    );

    // Casher side.
    modport slave (
        input  coin_insert, inserted_coin, return_coin, game_finish,
        output coin_reject, spit_coin, spit_code, eat_coins, game_active,
               timer_en, wait_ready, credit
    );

endinterface

// File: rtl/coin_escrow_casher_fifo.sv
// Escrow FIFO holding the codes of coins inserted since the last commit.
module coin_escrow_fifo
    import coin_casher_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [COIN_CODE_W-1:0] din,
    output logic                   full,
    output logic                   empty,
    output logic [COIN_CODE_W-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic [COIN_CODE_W-1:0] mem_q [DEPTH];
    logic [COIN_CODE_W-1:0] mem_d [DEPTH];
    logic                   do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointers/count; flush discards everything and wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)
                count_d = count_q + 1'b1;
            else if (!do_push && do_pop)
                count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy decides what is readable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/coin_escrow_casher.sv
// Coin casher: validates coins, accumulates credit, escrows coins for refund.
module coin_escrow_casher
    import coin_casher_pkg::*;
#(
    parameter int GAME_PRICE     = 4,
    parameter int CREDIT_W       = 8,
    parameter int ESCROW_DEPTH   = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input logic                 clk,
    input logic                 reset,
    coin_escrow_casher_if.slave bus
);

    localparam int                  TW       = $clog2(TIMEOUT_CYCLES);
    localparam int                  SUM_W    = CREDIT_W + 4;
    localparam logic [CREDIT_W-1:0] PRICE    = CREDIT_W'(GAME_PRICE);
    localparam logic [TW-1:0]       TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [CREDIT_W-1:0]    credit_q, credit_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   coin_reject_q, coin_reject_d;
    logic                   spit_coin_q, spit_coin_d;
    logic [COIN_CODE_W-1:0] spit_code_q, spit_code_d;
    logic                   eat_coins_q, eat_coins_d;
    logic                   game_active_q, timer_en_q, wait_ready_q;

    logic                   push, pop, flush, fifo_full, fifo_empty;
    logic [COIN_CODE_W-1:0] head_code;
    logic [3:0]             coin_val;
    logic [SUM_W-1:0]       sum;
    logic                   accept_ok;

    coin_escrow_fifo #(.DEPTH(ESCROW_DEPTH)) u_escrow (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (bus.inserted_coin),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (head_code)
    );

    assign coin_val  = coin_value(bus.inserted_coin);
    assign sum       = SUM_W'(credit_q) + SUM_W'(coin_val);
    assign accept_ok = bus.coin_insert && (coin_val != 4'd0) && !fifo_full
                       && (sum[SUM_W-1:CREDIT_W] == '0);

    // FSM, credit and timer next-state; refund beats price, price beats coins/timeout.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        timer_d       = '0;
        coin_reject_d = 1'b0;
        spit_coin_d   = 1'b0;
        spit_code_d   = '0;
        eat_coins_d   = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        flush         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_ok) begin
                    push     = 1'b1;
                    credit_d = sum[CREDIT_W-1:0];
                    state_d  = ST_COLLECT;
                end else begin
                    coin_reject_d = bus.coin_insert;
                end
            end
            ST_COLLECT: begin
                timer_d = timer_q + 1'b1;
                if (bus.return_coin) begin
                    state_d       = ST_REFUND;
                    timer_d       = '0;
                    coin_reject_d = bus.coin_insert;
                end else if (credit_q >= PRICE) begin
                    // Escrow is committed; a coin arriving now becomes carry credit.
                    state_d     = ST_PLAY;
                    timer_d     = '0;
                    eat_coins_d = 1'b1;
                    flush       = 1'b1;
                    if (accept_ok)
                        credit_d = sum[CREDIT_W-1:0] - PRICE;
                    else begin
                        credit_d      = credit_q - PRICE;
                        coin_reject_d = bus.coin_insert;
                    end
                end else if (accept_ok) begin
                    // An accepted coin restarts the idle window, even on the timeout cycle.
                    push     = 1'b1;
                    credit_d = sum[CREDIT_W-1:0];
                    timer_d  = '0;
                end else begin
                    coin_reject_d = bus.coin_insert;
                    if (timer_q == TO_LAST) begin
                        state_d = ST_REFUND;
                        timer_d = '0;
                    end
                end
            end
            ST_PLAY: begin
                coin_reject_d = bus.coin_insert;
                if (bus.game_finish) begin
                    if (credit_q >= PRICE) begin
                        eat_coins_d = 1'b1;
                        credit_d    = credit_q - PRICE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                coin_reject_d = bus.coin_insert;
                if (fifo_empty)
                    state_d = ST_IDLE;
            end
        endcase
        // Popping starts on the entry edge so the first spit shows in the first REFUND cycle.
        if (state_d == ST_REFUND && !fifo_empty) begin
            pop         = 1'b1;
            spit_coin_d = 1'b1;
            spit_code_d = head_code;
            credit_d    = credit_d - CREDIT_W'(coin_value(head_code));
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            timer_q       <= '0;
            coin_reject_q <= 1'b0;
            spit_coin_q   <= 1'b0;
            spit_code_q   <= '0;
            eat_coins_q   <= 1'b0;
            game_active_q <= 1'b0;
            timer_en_q    <= 1'b0;
            wait_ready_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            timer_q       <= timer_d;
            coin_reject_q <= coin_reject_d;
            spit_coin_q   <= spit_coin_d;
            spit_code_q   <= spit_code_d;
            eat_coins_q   <= eat_coins_d;
            game_active_q <= (state_d == ST_PLAY);
            timer_en_q    <= (state_d == ST_COLLECT);
            wait_ready_q  <= (state_d == ST_IDLE);
        end
    end

    assign bus.coin_reject = coin_reject_q;
    assign bus.spit_coin   = spit_coin_q;
    assign bus.spit_code   = spit_code_q;
    assign bus.eat_coins   = eat_coins_q;
    assign bus.game_active = game_active_q;
    assign bus.timer_en    = timer_en_q;
    assign bus.wait_ready  = wait_ready_q;
    assign bus.credit      = credit_q;

endmodule

// File: tb/tb_coin_escrow_casher.sv
// Directed bench for coin_escrow_casher (default DUT plus a high-price DUT).
module tb_coin_escrow_casher;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    coin_escrow_casher_if #(.CREDIT_W(8)) bus ();
    coin_escrow_casher_if #(.CREDIT_W(8)) bus_b ();

    coin_escrow_casher dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    coin_escrow_casher #(.GAME_PRICE(200), .CREDIT_W(8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic coin(input logic [2:0] code);
        bus.coin_insert   = 1'b1;
        bus.inserted_coin = code;
        tick();
        bus.coin_insert   = 1'b0;
        bus.inserted_coin = 3'd0;
    endtask

    task automatic finish_game();
        bus.game_finish = 1'b1;
        tick();
        bus.game_finish = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.coin_insert = 1'b0; bus.inserted_coin = 3'd0;
        bus.return_coin = 1'b0; bus.game_finish = 1'b0;
        bus_b.coin_insert = 1'b0; bus_b.inserted_coin = 3'd0;
        bus_b.return_coin = 1'b0; bus_b.game_finish = 1'b0;
        tick();
        tick();

        // Reset values
        chk("rst_wait_ready", bus.wait_ready, 1);
        chk("rst_credit", bus.credit, 0);
        chk("rst_active", bus.game_active, 0);
        chk("rst_timer_en", bus.timer_en, 0);
        chk("rst_spit", bus.spit_coin, 0);
        chk("rst_spit_code", bus.spit_code, 0);
        chk("rst_reject", bus.coin_reject, 0);
        chk("rst_eat", bus.eat_coins, 0);
        reset = 1'b0;

        // Escrow full on the high-price DUT: 8 x code 4 = 80, ninth rejected
        for (int i = 0; i < 8; i++) begin
            bus_b.coin_insert = 1'b1; bus_b.inserted_coin = 3'd4;
            tick();
            chk("full_fill_reject", bus_b.coin_reject, 0);
        end
        tick();
        chk("full_fill_credit", bus_b.credit, 80);
        bus_b.coin_insert = 1'b1; bus_b.inserted_coin = 3'd1;
        tick();
        bus_b.coin_insert = 1'b0; bus_b.inserted_coin = 3'd0;
        chk("full_ninth_reject", bus_b.coin_reject, 1);
        chk("full_ninth_credit", bus_b.credit, 80);

        // Exact price with two code-2 coins
        coin(3'd2);
        chk("exact_credit1", bus.credit, 2);
        chk("exact_timer_en", bus.timer_en, 1);
        chk("exact_wait_ready", bus.wait_ready, 0);
        coin(3'd2);
        chk("exact_credit2", bus.credit, 4);
        chk("exact_no_eat_yet", bus.eat_coins, 0);
        tick();
        chk("exact_eat", bus.eat_coins, 1);
        chk("exact_active", bus.game_active, 1);
        chk("exact_credit_play", bus.credit, 0);
        coin(3'd3);
        chk("play_coin_reject", bus.coin_reject, 1);
        chk("play_coin_credit", bus.credit, 0);
        chk("play_eat_done", bus.eat_coins, 0);
        finish_game();
        chk("exact_end_idle", bus.wait_ready, 1);
        chk("exact_end_active", bus.game_active, 0);

        // Invalid codes
        coin(3'd0);
        chk("code0_reject", bus.coin_reject, 1);
        chk("code0_credit", bus.credit, 0);
        coin(3'd6);
        chk("code6_reject", bus.coin_reject, 1);
        chk("code6_idle", bus.wait_ready, 1);

        // Refund of codes 1 then 3
        do_reset();
        coin(3'd1);
        coin(3'd3);
        chk("refund_credit", bus.credit, 6);
        bus.return_coin = 1'b1;
        tick();
        bus.return_coin = 1'b0;
        chk("refund_spit1", bus.spit_coin, 1);
        chk("refund_code1", bus.spit_code, 1);
        chk("refund_no_eat", bus.eat_coins, 0);
        chk("refund_credit1", bus.credit, 5);
        tick();
        chk("refund_spit2", bus.spit_coin, 1);
        chk("refund_code2", bus.spit_code, 3);
        chk("refund_credit2", bus.credit, 0);
        tick();
        chk("refund_spit_end", bus.spit_coin, 0);
        chk("refund_code_end", bus.spit_code, 0);
        chk("refund_idle", bus.wait_ready, 1);

        // Overpay with code 4 and a free continue
        do_reset();
        coin(3'd4);
        chk("over_credit", bus.credit, 10);
        tick();
        chk("over_eat", bus.eat_coins, 1);
        chk("over_carry", bus.credit, 6);
        finish_game();
        chk("cont_eat", bus.eat_coins, 1);
        chk("cont_active", bus.game_active, 1);
        chk("cont_credit", bus.credit, 2);
        finish_game();
        chk("cont_end_idle", bus.wait_ready, 1);
        chk("cont_end_eat", bus.eat_coins, 0);
        chk("cont_end_credit", bus.credit, 2);

        // Inactivity timeout refunds the single coin
        do_reset();
        coin(3'd1);
        repeat (999) tick();
        chk("to_before_timer_en", bus.timer_en, 1);
        chk("to_before_spit", bus.spit_coin, 0);
        tick();
        chk("to_spit", bus.spit_coin, 1);
        chk("to_code", bus.spit_code, 1);
        chk("to_credit", bus.credit, 0);
        tick();
        chk("to_idle", bus.wait_ready, 1);

        // Coin on the timeout cycle is accepted and restarts the window
        do_reset();
        coin(3'd1);
        repeat (999) tick();
        coin(3'd1);
        chk("to_coin_reject", bus.coin_reject, 0);
        chk("to_coin_spit", bus.spit_coin, 0);
        chk("to_coin_credit", bus.credit, 2);
        tick();
        chk("to_coin_collect", bus.timer_en, 1);
        chk("to_coin_no_spit", bus.spit_coin, 0);

        // Return together with a coin: coin rejected, refund proceeds
        do_reset();
        coin(3'd1);
        bus.coin_insert = 1'b1; bus.inserted_coin = 3'd2; bus.return_coin = 1'b1;
        tick();
        bus.coin_insert = 1'b0; bus.inserted_coin = 3'd0; bus.return_coin = 1'b0;
        chk("ret_coin_reject", bus.coin_reject, 1);
        chk("ret_coin_spit", bus.spit_coin, 1);
        chk("ret_coin_code", bus.spit_code, 1);
        chk("ret_coin_credit", bus.credit, 0);
        tick();
        chk("ret_coin_idle", bus.wait_ready, 1);

        // Reset in the middle of a refund
        do_reset();
        coin(3'd1);
        coin(3'd1);
        coin(3'd1);
        bus.return_coin = 1'b1;
        tick();
        bus.return_coin = 1'b0;
        chk("mid_spit", bus.spit_coin, 1);
        chk("mid_credit", bus.credit, 2);
        do_reset();
        chk("mid_rst_spit", bus.spit_coin, 0);
        chk("mid_rst_code", bus.spit_code, 0);
        chk("mid_rst_credit", bus.credit, 0);
        chk("mid_rst_idle", bus.wait_ready, 1);
        chk("mid_rst_timer_en", bus.timer_en, 0);
        tick();
        chk("mid_rst_stays", bus.spit_coin, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
